// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the unified MIPS memory port: FSM/source encodings
// and the memory geometry defaults also used by the memory model.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_t;

  localparam int DEF_RAM_SIZE_BIT  = 8;
  localparam int DEF_RAM_INST_SIZE = 32;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core request/response channels plus the memory port of mem_access_ctrl.
// master = core and memory model side, slave = the access controller.
interface mem_access_ctrl_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;

  logic        rsp_err;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data;

  modport master (
    output if_req_valid, if_addr,
    output dm_req_valid, dm_addr, dm_we, dm_wdata,
    output mem_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data, rsp_err,
    input  mem_address, mem_write_data, mem_read, mem_write
  );

  modport slave (
    input  if_req_valid, if_addr,
    input  dm_req_valid, dm_addr, dm_we, dm_wdata,
    input  mem_data,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data, rsp_err,
    output mem_address, mem_write_data, mem_read, mem_write
  );

endinterface

// File: rtl/mem_access_ctrl_req_check.sv
// Combinational request legality check: alignment, address range and
// write protection of the instruction region.
module mem_req_check
  import mips_mem_pkg::*;
#(
  parameter int RAM_SIZE_BIT  = DEF_RAM_SIZE_BIT,
  parameter int RAM_INST_SIZE = DEF_RAM_INST_SIZE
) (
  input  logic [31:0] addr,
  input  logic        we,
  output logic        err
);

  localparam logic [31:0] INST_LIMIT = RAM_INST_SIZE;

  logic [31:0] word_idx_s;
  logic        misaligned_s;
  logic        out_of_range_s;
  logic        inst_write_s;

  // Classify the byte address against the memory geometry
  always_comb begin
    word_idx_s                     = 32'd0;
    word_idx_s[RAM_SIZE_BIT-1:0]   = addr[RAM_SIZE_BIT+1:2];
    misaligned_s                   = (addr[1:0] != 2'b00);
    out_of_range_s                 = |addr[31:RAM_SIZE_BIT+2];
    inst_write_s                   = we && (word_idx_s < INST_LIMIT);
    err                            = misaligned_s || out_of_range_s || inst_write_s;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the unified instruction/data memory port: arbitrates fetch
// and load/store requests and performs one checked memory access per request.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int RAM_SIZE_BIT  = DEF_RAM_SIZE_BIT,
  parameter int RAM_INST_SIZE = DEF_RAM_INST_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus
);

  state_t      state_r;
  src_t        src_r;
  logic        we_r;
  logic        err_r;
  logic [31:0] mem_address_r;
  logic [31:0] mem_write_data_r;
  logic        mem_read_r;
  logic        mem_write_r;
  logic        if_rsp_valid_r;
  logic        dm_rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] if_rsp_data_r;
  logic [31:0] dm_rsp_data_r;

  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_we_s;
  logic        sel_dm_s;
  logic        chk_err_s;
  logic        idle_s;
  logic        accept_s;

  // Data channel has fixed priority over instruction fetch
  always_comb begin
    sel_addr_s  = 32'd0;
    sel_wdata_s = 32'd0;
    sel_we_s    = 1'b0;
    sel_dm_s    = 1'b0;
    if (bus.dm_req_valid) begin
      sel_addr_s  = bus.dm_addr;
      sel_wdata_s = bus.dm_wdata;
      sel_we_s    = bus.dm_we;
      sel_dm_s    = 1'b1;
    end else begin
      sel_addr_s  = bus.if_addr;
      sel_wdata_s = 32'd0;
      sel_we_s    = 1'b0;
      sel_dm_s    = 1'b0;
    end
  end

  mem_req_check #(
    .RAM_SIZE_BIT  (RAM_SIZE_BIT),
    .RAM_INST_SIZE (RAM_INST_SIZE)
  ) u_req_check (
    .addr (sel_addr_s),
    .we   (sel_we_s),
    .err  (chk_err_s)
  );

  assign idle_s   = (state_r == IDLE);
  assign accept_s = idle_s && (bus.dm_req_valid || bus.if_req_valid);

  // Ready must also read 0 while reset is held, so it is qualified here
  assign bus.dm_req_ready = idle_s && !reset;
  assign bus.if_req_ready = idle_s && !reset && !bus.dm_req_valid;

  // Request/access/response sequencer with registered memory and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      src_r            <= SRC_IF;
      we_r             <= 1'b0;
      err_r            <= 1'b0;
      mem_address_r    <= 32'd0;
      mem_write_data_r <= 32'd0;
      mem_read_r       <= 1'b0;
      mem_write_r      <= 1'b0;
      if_rsp_valid_r   <= 1'b0;
      dm_rsp_valid_r   <= 1'b0;
      rsp_err_r        <= 1'b0;
      if_rsp_data_r    <= 32'd0;
      dm_rsp_data_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= ACCESS;
            src_r   <= sel_dm_s ? SRC_DM : SRC_IF;
            we_r    <= sel_we_s;
            err_r   <= chk_err_s;
            // Rejected requests never reach the memory strobes
            if (chk_err_s) begin
              mem_address_r    <= 32'd0;
              mem_write_data_r <= 32'd0;
              mem_read_r       <= 1'b0;
              mem_write_r      <= 1'b0;
            end else begin
              mem_address_r    <= sel_addr_s;
              mem_write_data_r <= sel_wdata_s;
              mem_read_r       <= !sel_we_s;
              mem_write_r      <= sel_we_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r          <= RESP;
          mem_address_r    <= 32'd0;
          mem_write_data_r <= 32'd0;
          mem_read_r       <= 1'b0;
          mem_write_r      <= 1'b0;
          rsp_err_r        <= err_r;
          if (src_r == SRC_DM) begin
            dm_rsp_valid_r <= 1'b1;
            dm_rsp_data_r  <= (err_r || we_r) ? 32'd0 : bus.mem_data;
          end else begin
            if_rsp_valid_r <= 1'b1;
            if_rsp_data_r  <= err_r ? 32'd0 : bus.mem_data;
          end
        end
        RESP: begin
          state_r        <= IDLE;
          if_rsp_valid_r <= 1'b0;
          dm_rsp_valid_r <= 1'b0;
          rsp_err_r      <= 1'b0;
        end
        default: begin
          state_r          <= IDLE;
          mem_address_r    <= 32'd0;
          mem_write_data_r <= 32'd0;
          mem_read_r       <= 1'b0;
          mem_write_r      <= 1'b0;
          if_rsp_valid_r   <= 1'b0;
          dm_rsp_valid_r   <= 1'b0;
          rsp_err_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_address    = mem_address_r;
  assign bus.mem_write_data = mem_write_data_r;
  assign bus.mem_read       = mem_read_r;
  assign bus.mem_write      = mem_write_r;
  assign bus.if_rsp_valid   = if_rsp_valid_r;
  assign bus.if_rsp_data    = if_rsp_data_r;
  assign bus.dm_rsp_valid   = dm_rsp_valid_r;
  assign bus.dm_rsp_data    = dm_rsp_data_r;
  assign bus.rsp_err        = rsp_err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the memory port.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];

  assign bus.mem_data = ram[bus.mem_address[9:2]];

  always @(posedge clk) begin
    if (bus.mem_write) ram[bus.mem_address[9:2]] <= bus.mem_write_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input bit st);
    return (a % 32'd4 != 32'd0) || (a >= 32'd1024) || (st && (a / 32'd4 < 32'd32));
  endfunction

  // ---------------- transaction-level model + per-cycle compare ----------
  int          cyc = 0;
  int          free_cyc = 0;
  int          acc_cyc = 0;
  bit          infl = 1'b0;
  bit          m_dm, m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] exp_if_data = 32'd0;
  logic [31:0] exp_dm_data = 32'd0;
  bit          acc_if = 1'b0;
  bit          acc_dm = 1'b0;
  int          mem_read_cycles = 0;

  always @(negedge clk) begin
    bit mem_on, rsp_on, idle;
    cyc++;
    if (bus.mem_read) mem_read_cycles++;
    if (reset) begin
      infl = 1'b0; free_cyc = 0; acc_if = 1'b0; acc_dm = 1'b0;
      exp_if_data = 32'd0; exp_dm_data = 32'd0;
      chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
      chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
      chk("rst_mem_address", bus.mem_address, 32'd0);
      chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
      chk("rst_if_ready", {31'd0, bus.if_req_ready}, 32'd0);
      chk("rst_dm_ready", {31'd0, bus.dm_req_ready}, 32'd0);
      chk("rst_rsp_valids", {30'd0, bus.if_rsp_valid, bus.dm_rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      chk("rst_if_data", bus.if_rsp_data, 32'd0);
      chk("rst_dm_data", bus.dm_rsp_data, 32'd0);
    end else begin
      mem_on = infl && (cyc == acc_cyc + 1) && !m_err;
      rsp_on = infl && (cyc == acc_cyc + 2);
      if (infl && (cyc == acc_cyc + 1)) begin
        m_rdata = (m_err || m_we) ? 32'd0 : ref_mem[m_addr / 32'd4];
        if (!m_err && m_we) ref_mem[m_addr / 32'd4] = m_wdata;
      end
      chk("mem_read", {31'd0, bus.mem_read}, {31'd0, mem_on && !m_we});
      chk("mem_write", {31'd0, bus.mem_write}, {31'd0, mem_on && m_we});
      chk("mem_address", bus.mem_address, mem_on ? m_addr : 32'd0);
      if (!mem_on) chk("mem_wdata_idle", bus.mem_write_data, 32'd0);
      else if (m_we) chk("mem_wdata", bus.mem_write_data, m_wdata);
      if (rsp_on) begin
        if (m_dm) exp_dm_data = m_rdata;
        else exp_if_data = m_rdata;
        infl = 1'b0;
      end
      chk("if_rsp_valid", {31'd0, bus.if_rsp_valid}, {31'd0, rsp_on && !m_dm});
      chk("dm_rsp_valid", {31'd0, bus.dm_rsp_valid}, {31'd0, rsp_on && m_dm});
      chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, rsp_on && m_err});
      chk("if_rsp_data", bus.if_rsp_data, exp_if_data);
      chk("dm_rsp_data", bus.dm_rsp_data, exp_dm_data);
      chk("rsp_overlap", {31'd0, bus.if_rsp_valid && bus.dm_rsp_valid}, 32'd0);
      idle = (cyc >= free_cyc);
      chk("dm_req_ready", {31'd0, bus.dm_req_ready}, {31'd0, idle});
      chk("if_req_ready", {31'd0, bus.if_req_ready}, {31'd0, idle && !bus.dm_req_valid});
      acc_dm = idle && bus.dm_req_valid;
      acc_if = idle && !bus.dm_req_valid && bus.if_req_valid;
      if (acc_dm || acc_if) begin
        infl     = 1'b1;
        acc_cyc  = cyc;
        free_cyc = cyc + 3;
        m_dm     = acc_dm;
        m_addr   = acc_dm ? bus.dm_addr : bus.if_addr;
        m_we     = acc_dm ? bus.dm_we : 1'b0;
        m_wdata  = bus.dm_wdata;
        m_err    = model_err(m_addr, m_we);
      end
    end
  end

  // ---------------- stimulus ----------------
  int tick_no = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    ram[idx]     = val;
    ref_mem[idx] = val;
  endtask

  // Issue one request, wait for acceptance, return the response seen in RESP
  task automatic do_req(input bit dm, input logic [31:0] a, input bit we,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output bit rerr);
    int n = 0;
    if (dm) begin
      bus.dm_req_valid = 1'b1; bus.dm_addr = a; bus.dm_we = we; bus.dm_wdata = wd;
    end else begin
      bus.if_req_valid = 1'b1; bus.if_addr = a;
    end
    do begin tick(); n++; end while (!(dm ? acc_dm : acc_if) && n < 20);
    chk("accept_timeout", {31'd0, dm ? acc_dm : acc_if}, 32'd1);
    bus.dm_req_valid = 1'b0;
    bus.if_req_valid = 1'b0;
    tick();
    rdata = dm ? bus.dm_rsp_data : bus.if_rsp_data;
    rerr  = bus.rsp_err;
    chk("rsp_pulse", {31'd0, dm ? bus.dm_rsp_valid : bus.if_rsp_valid}, 32'd1);
    tick();
  endtask

  function automatic logic [31:0] rand_addr(input bit st);
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
      1: a = 32'h0000_0400 + ($urandom_range(0, 4095) << 2);
      2: a = $urandom_range(0, 31) << 2;
      default: a = (st ? $urandom_range(32, 255) : $urandom_range(0, 255)) << 2;
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] rd;
    bit          re;
    int          n;
    int          acc_t [4];
    int          rd_before;
    logic [31:0] fetch_addr [4];

    bus.if_req_valid = 1'b0; bus.if_addr = 32'd0;
    bus.dm_req_valid = 1'b0; bus.dm_addr = 32'd0;
    bus.dm_we = 1'b0; bus.dm_wdata = 32'd0;
    for (int i = 0; i < 256; i++) set_word(i, 32'hA500_0000 | i);
    set_word(2, 32'h0C00_0004);
    set_word(3, 32'h8C0A_0010);
    set_word(5, 32'hAC0B_0014);
    set_word(6, 32'h1000_FFFF);

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1: fetch
    rd_before = mem_read_cycles;
    do_req(1'b0, 32'h0000_0008, 1'b0, 32'd0, rd, re);
    chk("t1_ir", rd, 32'h0C00_0004);
    chk("t1_err", {31'd0, re}, 32'd0);
    chk("t1_read_pulses", mem_read_cycles - rd_before, 32'd1);

    // 2: store then load
    do_req(1'b1, 32'h0000_0080, 1'b1, 32'hDEAD_BEEF, rd, re);
    chk("t2_store_err", {31'd0, re}, 32'd0);
    chk("t2_store_data", rd, 32'd0);
    do_req(1'b1, 32'h0000_0080, 1'b0, 32'd0, rd, re);
    chk("t2_load", rd, 32'hDEAD_BEEF);

    // 3: simultaneous requests, data wins
    bus.dm_req_valid = 1'b1; bus.dm_addr = 32'h0000_0080; bus.dm_we = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h0000_0008;
    #1;
    chk("t3_if_ready", {31'd0, bus.if_req_ready}, 32'd0);
    chk("t3_dm_ready", {31'd0, bus.dm_req_ready}, 32'd1);
    tick();
    chk("t3_dm_first", {31'd0, acc_dm}, 32'd1);
    bus.dm_req_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!acc_if && n < 20);
    chk("t3_if_gap", n, 32'd3);
    bus.if_req_valid = 1'b0;
    repeat (2) tick();
    chk("t3_if_data", bus.if_rsp_data, 32'h0C00_0004);
    chk("t3_dm_data", bus.dm_rsp_data, 32'hDEAD_BEEF);

    // 4: rejected requests
    do_req(1'b1, 32'h0000_0082, 1'b0, 32'd0, rd, re);
    chk("t4_misaligned_err", {31'd0, re}, 32'd1);
    chk("t4_misaligned_data", rd, 32'd0);
    do_req(1'b1, 32'h0000_0010, 1'b1, 32'h1234_5678, rd, re);
    chk("t4_protect_err", {31'd0, re}, 32'd1);
    chk("t4_protect_word", ram[4], 32'hA500_0004);
    do_req(1'b0, 32'h0000_0400, 1'b0, 32'd0, rd, re);
    chk("t4_range_err", {31'd0, re}, 32'd1);

    // 5: asynchronous reset during the ACCESS cycle of a store
    bus.dm_req_valid = 1'b1; bus.dm_addr = 32'h0000_0100; bus.dm_we = 1'b1;
    bus.dm_wdata = 32'h1234_5678;
    n = 0;
    do begin tick(); n++; end while (!acc_dm && n < 20);
    chk("t5_accept", {31'd0, acc_dm}, 32'd1);
    chk("t5_write_on", {31'd0, bus.mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_write_drop", {31'd0, bus.mem_write}, 32'd0);
    chk("t5_addr_drop", bus.mem_address, 32'd0);
    chk("t5_dm_ready", {31'd0, bus.dm_req_ready}, 32'd0);
    bus.dm_req_valid = 1'b0; bus.dm_we = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("t5_word_kept", ram[64], 32'hA500_0040);
    do_req(1'b1, 32'h0000_0100, 1'b0, 32'd0, rd, re);
    chk("t5_after_load", rd, 32'hA500_0040);
    chk("t5_after_err", {31'd0, re}, 32'd0);

    // 6: back-to-back fetches with valid held
    fetch_addr[0] = 32'h0000_0008; fetch_addr[1] = 32'h0000_000C;
    fetch_addr[2] = 32'h0000_0014; fetch_addr[3] = 32'h0000_0018;
    bus.if_req_valid = 1'b1; bus.if_addr = fetch_addr[0];
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin tick(); n++; end while (!acc_if && n < 20);
      chk("t6_accept", {31'd0, acc_if}, 32'd1);
      acc_t[k] = tick_no;
      if (k < 3) bus.if_addr = fetch_addr[k+1];
      else bus.if_req_valid = 1'b0;
    end
    for (int k = 1; k < 4; k++) chk("t6_spacing", acc_t[k] - acc_t[k-1], 32'd3);
    repeat (3) tick();
    chk("t6_last_ir", bus.if_rsp_data, 32'h1000_FFFF);

    // Random traffic on both channels
    for (int c = 0; c < 600; c++) begin
      if (acc_dm) bus.dm_req_valid = 1'b0;
      if (acc_if) bus.if_req_valid = 1'b0;
      if (!bus.dm_req_valid && $urandom_range(0, 2) == 0) begin
        bus.dm_we        = $urandom_range(0, 1);
        bus.dm_addr      = rand_addr(bus.dm_we);
        bus.dm_wdata     = $urandom();
        bus.dm_req_valid = 1'b1;
      end
      if (!bus.if_req_valid && $urandom_range(0, 1) == 0) begin
        bus.if_addr      = rand_addr(1'b0);
        bus.if_req_valid = 1'b1;
      end
      tick();
    end
    bus.dm_req_valid = 1'b0;
    bus.if_req_valid = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 256; i++) chk("final_mem", ram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the unified instruction/data memory port used by the multi-cycle MIPS core.
- Accepts instruction-fetch and load/store requests from the core over two valid/ready channels and arbitrates between them.
- Drives one access per request onto the memory's Address/Write_data/MemRead/MemWrite port and registers Mem_data.
- Returns responses with a one-cycle valid pulse, and rejects misaligned, out-of-range and instruction-region-write requests.

Parameters:
- RAM_SIZE_BIT, 8, word-index width of the memory (memory depth = 2**RAM_SIZE_BIT words).
- RAM_INST_SIZE, 32, number of low words holding instructions; data writes to word index < RAM_INST_SIZE are forbidden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address (PC)
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  32  fetched instruction (IR value)
- dm_req_valid  in  1  data request valid
- dm_req_ready  out  1  data request accepted this cycle
- dm_addr  in  32  data byte address
- dm_we  in  1  1 = store, 0 = load
- dm_wdata  in  32  store data
- dm_rsp_valid  out  1  data response pulse (load data or store completion)
- dm_rsp_data  out  32  load data (MDR value); 0 for stores
- rsp_err  out  1  qualifies the rsp_valid pulse: request was rejected
- mem_address  out  32  to memory Address
- mem_write_data  out  32  to memory Write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_data  in  32  from memory Mem_data (combinational read)

Behaviour:
- Reset and idle values:
  - Reset values: state IDLE; every output 0; the internal request registers (addr, wdata, we, source) are 0.
  - mem_address, mem_write_data, mem_read and mem_write are 0 in every state except ACCESS.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - if_req_ready = dm_req_ready = 1 only in IDLE.
  - Fixed priority: if dm_req_valid, the data channel is accepted and if_req_ready drops to 0 that cycle. Otherwise a valid fetch is accepted.
  - On acceptance, register addr, wdata, we (forced 0 for fetch), source and the error check, then go to ACCESS. The error check is:
    - addr[1:0] != 0, or
    - addr[31:RAM_SIZE_BIT+2] != 0, or
    - a data store with addr[RAM_SIZE_BIT+1:2] < RAM_INST_SIZE.
- ACCESS (exactly one cycle):
  - If there is no error: mem_address = registered addr; mem_read = !we; mem_write = we; mem_write_data = wdata. Mem_data is captured into the response data register at the clock edge.
  - If there is an error: mem_read = mem_write = 0, and the response data is 0.
  - Next state: RESP.
- RESP (exactly one cycle):
  - The selected rsp_valid is 1 and rsp_err is the registered error flag.
  - Response data holds its value until the next response of the same channel.
  - Next state: IDLE.
- Latency:
  - Request accepted at edge N; memory accessed in cycle N+1; rsp_valid high in cycle N+2.
  - Next acceptance is no earlier than cycle N+3, giving a throughput of one request per 3 cycles.
- Store data and the write strobe are asserted for exactly one cycle, so the memory sees a single write edge.
- Requests that arrive while not in IDLE are held by the requester (valid stays high) and are not lost. The requester must keep addr/data stable until ready.
- Asynchronous reset in ACCESS or RESP:
  - Aborts immediately; mem_write drops without waiting for the clock.
  - No response is generated and the in-flight request is dropped.
- Only one channel's rsp_valid is high in any cycle.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - source encoding (SRC_IF=0, SRC_DM=1);
  - RAM_SIZE_BIT / RAM_INST_SIZE defaults, shared with the memory model.
- One sub-module, mem_req_check: purely combinational alignment/range/protection checker (address, we in; err out), reused by the data-memory-side model for assertions.

Test Plan:
1. Fetch: if_addr=0x00000008, memory word 2 = 0x0C000004. Required: if_rsp_valid exactly 2 cycles after acceptance, if_rsp_data=0x0C000004, rsp_err=0, mem_read high for exactly 1 cycle.
2. Store then load: dm_we=1, addr=0x00000080, wdata=0xDEADBEEF, then dm_we=0 to the same address. Required: mem_write is a one-cycle pulse with mem_address=0x80; the load returns dm_rsp_data=0xDEADBEEF.
3. Simultaneous if_req_valid and dm_req_valid in IDLE. Required: data is served first and if_req_ready=0 that cycle. The fetch is accepted 3 cycles later, both respond correctly, and no overlapping rsp_valid occurs.
4. Errors, each with no memory strobe:
   - Misaligned load 0x00000082: dm_rsp_valid with rsp_err=1, dm_rsp_data=0.
   - Store to 0x00000010 (word 4 < 32): rsp_err=1, memory word unchanged.
   - Fetch 0x00000400 (out of range): rsp_err=1.
5. Reset asserted asynchronously during the ACCESS cycle of a store. Required: mem_write falls immediately, no dm_rsp_valid, all outputs 0, and the next request completes normally.
6. Back-to-back fetches with valid held high for 4 requests. Required: one acceptance every 3 cycles and responses in order with the correct IR values.
